// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for a 7-segment bus.
// Filters glitches, decodes hex glyphs, locks onto flash/rotate animations.
module seg7_monitor #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] seg_i,
   output logic [6:0] pattern_o,
   output logic       new_pat_o,
   output logic [3:0] digit_o,
   output logic       digit_valid_o,
   output logic       blank_o,
   output logic       mode_valid_o,
   output logic       mode_o,
   output logic [2:0] rot_pos_o
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      FLASH_TRY,
      FLASH_LOCK,
      ROT_TRY,
      ROT_LOCK
   } state_t;

   logic [6:0]    sync1, sync2, cand, prev_pat;
   logic [SW-1:0] stab_cnt, stab_nxt;
   logic [TW-1:0] to_cnt;
   logic          reached, accept;
   logic [4:0]    dec;
   state_t        state, state_nxt;
   logic [1:0]    cnt, cnt_nxt;
   logic          flash_step, rot_step, timeout;
   logic [2:0]    pos;

   function automatic logic [4:0] hex_dec(input logic [6:0] p);
      case (p)
         7'h3F:   hex_dec = 5'h10;
         7'h06:   hex_dec = 5'h11;
         7'h5B:   hex_dec = 5'h12;
         7'h4F:   hex_dec = 5'h13;
         7'h66:   hex_dec = 5'h14;
         7'h6D:   hex_dec = 5'h15;
         7'h7D:   hex_dec = 5'h16;
         7'h07:   hex_dec = 5'h17;
         7'h7F:   hex_dec = 5'h18;
         7'h6F:   hex_dec = 5'h19;
         7'h77:   hex_dec = 5'h1A;
         7'h7C:   hex_dec = 5'h1B;
         7'h39:   hex_dec = 5'h1C;
         7'h5E:   hex_dec = 5'h1D;
         7'h79:   hex_dec = 5'h1E;
         7'h71:   hex_dec = 5'h1F;
         default: hex_dec = 5'h00;
      endcase
   endfunction

   // Accept only on the edge the count first reaches the threshold.
   always_comb begin
      stab_nxt = stab_cnt;
      reached  = 1'b0;
      if (sync2 != cand) begin
         stab_nxt = SW'(1);
         reached  = (STAB_MAX == SW'(1));
      end else if (stab_cnt != STAB_MAX) begin
         stab_nxt = stab_cnt + SW'(1);
         reached  = (stab_nxt == STAB_MAX);
      end
      accept = reached && (sync2 != pattern_o);
      dec    = hex_dec(sync2);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1         <= '0;
         sync2         <= '0;
         cand          <= '0;
         stab_cnt      <= '0;
         prev_pat      <= '0;
         pattern_o     <= '0;
         new_pat_o     <= 1'b0;
         digit_o       <= '0;
         digit_valid_o <= 1'b0;
         blank_o       <= 1'b1;
         to_cnt        <= '0;
      end else begin
         sync1     <= seg_i;
         sync2     <= sync1;
         cand      <= sync2;
         stab_cnt  <= stab_nxt;
         new_pat_o <= accept;
         if (accept) begin
            prev_pat      <= pattern_o;
            pattern_o     <= sync2;
            digit_valid_o <= dec[4];
            digit_o       <= dec[3:0];
            blank_o       <= (sync2 == 7'h00);
         end
         if (new_pat_o) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TW'(1);
         end
      end
   end

   assign flash_step =
      ((prev_pat == 7'h7F) && (pattern_o == 7'h00)) ||
      ((prev_pat == 7'h00) && (pattern_o == 7'h7F));
   assign rot_step = !prev_pat[6] && $onehot(prev_pat[5:0]) &&
      (pattern_o == {1'b0, prev_pat[4:0], prev_pat[5]});
   assign timeout = (to_cnt == TO_MAX);

   always_comb begin
      case (pattern_o)
         7'h01:   pos = 3'd0;
         7'h02:   pos = 3'd1;
         7'h04:   pos = 3'd2;
         7'h08:   pos = 3'd3;
         7'h10:   pos = 3'd4;
         7'h20:   pos = 3'd5;
         default: pos = 3'd0;
      endcase
   end

   // A pattern event outranks a coincident timeout.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (new_pat_o) begin
         if (flash_step) begin
            state_nxt = FLASH_TRY;
            cnt_nxt   = 2'd1;
         end else if (rot_step) begin
            state_nxt = ROT_TRY;
            cnt_nxt   = 2'd1;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
         unique case (state)
            FLASH_TRY: if (flash_step) begin
               state_nxt = FLASH_LOCK;
               cnt_nxt   = 2'd2;
            end
            FLASH_LOCK: if (flash_step) begin
               state_nxt = FLASH_LOCK;
               cnt_nxt   = cnt;
            end
            ROT_TRY: if (rot_step) begin
               cnt_nxt   = cnt + 2'd1;
               state_nxt = (cnt == 2'd2) ? ROT_LOCK : ROT_TRY;
            end
            ROT_LOCK: if (rot_step) begin
               state_nxt = ROT_LOCK;
               cnt_nxt   = cnt;
            end
            default: ;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
         cnt_nxt   = 2'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         cnt          <= '0;
         mode_valid_o <= 1'b0;
         mode_o       <= 1'b0;
         rot_pos_o    <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         mode_valid_o <= (state_nxt == FLASH_LOCK) ||
                         (state_nxt == ROT_LOCK);
         mode_o       <= (state_nxt == ROT_LOCK);
         rot_pos_o    <= (state_nxt == ROT_LOCK) ? pos : 3'd0;
      end
   end

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Receive-side checker for a 7-segment bus: samples a segment pattern driven by an animator or digit driver, rejects glitches, decodes hex digits, and classifies the animation as flash or rotate. Sits on the observing end of a segment bus, either on-chip as a self-check of the display path or on pins from an external board. All outputs are registered and single-clock.

## Interface

- `STABLE_CYCLES`, default 4: consecutive synchronized cycles a pattern must hold before it is accepted; must be ≥1.
- `TIMEOUT_CYCLES`, default 50_000_000: cycles without an accepted pattern change before mode lock drops (1 s at 50 MHz); must be ≥2.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `seg_i`, input, 7: segment bus, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- `pattern_o`, output, 7: last accepted stable pattern.
- `new_pat_o`, output, 1: one-cycle pulse when the accepted pattern changes.
- `digit_o`, output, 4: hex value of `pattern_o`; 0 when the pattern is not a hex glyph.
- `digit_valid_o`, output, 1: `pattern_o` matches a hex glyph.
- `blank_o`, output, 1: `pattern_o` == 7'h00.
- `mode_valid_o`, output, 1: an animation mode is locked.
- `mode_o`, output, 1: 0 = flash, 1 = rotate; meaningful only when `mode_valid_o` = 1.
- `rot_pos_o`, output, 3: index 0..5 of the lit segment (a..f) while rotate is locked; 0 otherwise.

## Operation

- **Input synchronization.** `seg_i` passes through a 2-flop synchronizer, all 7 bits in parallel.
- **Stability filter.**
  - When the synchronized value differs from the candidate: load the candidate and set the counter to 1.
  - When it matches: increment the counter, saturating at `STABLE_CYCLES`.
  - On the edge the counter reaches `STABLE_CYCLES` with a candidate that differs from `pattern_o`: update `pattern_o` and pulse `new_pat_o`.
  - A candidate equal to `pattern_o` never pulses.
- **Hex decode table.** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Any other pattern gives `digit_valid_o`=0 and `digit_o`=0.
- **Mode FSM.** States are IDLE, FLASH_TRY, FLASH_LOCK, ROT_TRY and ROT_LOCK. The FSM is evaluated only on `new_pat_o` events or on timeout.
  - **Flash step:** a change 7F→00 or 00→7F.
  - **Rotate step:** a change one-hot(k)→one-hot((k+1) mod 6), with k in 0..5 (bits a..f; g never participates).
  - **IDLE:**
    - Flash step → FLASH_TRY, cnt=1.
    - Rotate step → ROT_TRY, cnt=1.
    - Otherwise stay.
  - **FLASH_TRY:** a flash step increments cnt; at cnt=2 go to FLASH_LOCK.
  - **ROT_TRY:** a rotate step increments cnt; at cnt=3 go to ROT_LOCK.
  - **FLASH_LOCK / ROT_LOCK:** a matching step stays.
  - **Mismatch in any non-IDLE state:** re-evaluate the event as if in IDLE. For example, a flash step arriving in ROT_TRY goes to FLASH_TRY with cnt=1.
  - **Outputs:** `mode_valid_o`=1 only in the two LOCK states. `mode_o`=1 in ROT_LOCK. `rot_pos_o` is the one-hot index of `pattern_o` in ROT_LOCK, otherwise 0.
- **Timeout.** The timeout counter clears on every `new_pat_o`. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE with cnt=0 and the counter holds until the next `new_pat_o`.
- **Reset (`rst_ni`=0).** Immediately clears all state: synchronizer, candidate, counters, FSM (to IDLE). Output reset values:
  - `pattern_o`=00, `new_pat_o`=0, `digit_o`=0, `digit_valid_o`=0.
  - `blank_o`=1.
  - `mode_valid_o`=0, `mode_o`=0, `rot_pos_o`=0.
  - After deassertion, a bus held at 00 produces no pulse.

## Timing

- **Latency.** `seg_i` changes before edge 0 and is then held. `pattern_o`, `new_pat_o`, `digit_*` and `blank_o` update on edge `STABLE_CYCLES`+1.
- **FSM latency.** `mode_*` and `rot_pos_o` update one edge after `new_pat_o`.
- **Glitch rejection.** A synchronized value lasting fewer than `STABLE_CYCLES` cycles is ignored.
- **Pulse spacing.** Back-to-back `new_pat_o` pulses are at least `STABLE_CYCLES` cycles apart.
- **Simultaneous events.** If a timeout and a `new_pat_o` occur in the same cycle, the pattern event wins: the FSM evaluates the step, not the timeout.
- **Arithmetic.** Stability counter width is clog2(`STABLE_CYCLES`+1); timeout counter width is clog2(`TIMEOUT_CYCLES`+1); both are saturating, with no wrap-around.

## Test plan

All scenarios use `STABLE_CYCLES`=4 and `TIMEOUT_CYCLES`=100.

- **Reset.** Assert `rst_ni`=0 mid-operation in ROT_LOCK → all outputs take their reset values immediately. Release with `seg_i`=00 → no `new_pat_o` for 20 cycles.
- **Hex decode.** Hold 5B for 10 cycles → `new_pat_o` pulses once on edge 5, `digit_o`=2, `digit_valid_o`=1. Then hold 7'h41 → `digit_valid_o`=0, `digit_o`=0.
- **Glitch.** From stable 06, drive 3F for 3 cycles then back to 06 → no pulse and `pattern_o` stays 06. Driving 3F for 4 cycles → pulse, `digit_o`=0.
- **Flash.** Alternate 7F/00 every 20 cycles → `mode_valid_o`=1 and `mode_o`=0 one edge after the 2nd flash step. Then hold for 101+ cycles → `mode_valid_o`=0.
- **Rotate.** Sequence 01,02,04,08,10,20,01, 20 cycles each → lock one edge after the 3rd step, `mode_o`=1, `rot_pos_o` tracks 3,4,5,0. Inject 40 → `mode_valid_o`=0, FSM in IDLE.
- **Simultaneous.** Time a rotate step's `new_pat_o` exactly on the timeout cycle while in ROT_TRY with cnt=2 → FSM goes to ROT_LOCK, not IDLE.
